// File: rtl/lsc_i2cs_pkg.sv
// Shared FSM encoding and constants for the lsc_i2cs_16 I2C target.
package lsc_i2cs_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DEV     = 4'd1,
    ACK_DEV = 4'd2,
    OFS_H   = 4'd3,
    ACK_H   = 4'd4,
    OFS_L   = 4'd5,
    ACK_L   = 4'd6,
    WDAT    = 4'd7,
    ACK_W   = 4'd8,
    RDAT    = 4'd9,
    RACK    = 4'd10
  } state_t;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h24;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;

endpackage

// File: rtl/lsc_i2c_filt.sv
// One-bit pad conditioner: 2-flop synchronizer, FILT_LEN stability filter,
// and single-cycle rise/fall pulses of the filtered level.
module lsc_i2c_filt #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_pad,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic [3:0] r_cnt;
  logic       r_filt;
  logic       r_prev;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync <= '1;
      r_cnt  <= '0;
      r_filt <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_pad};
      r_prev <= r_filt;
      // A new level is accepted only after FILT_LEN identical samples in a row
      if (r_sync[1] != r_filt) begin
        if (r_cnt == 4'(FILT_LEN - 1)) begin
          r_filt <= r_sync[1];
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_lvl  = r_filt;
  assign o_rise = r_filt & ~r_prev;
  assign o_fall = ~r_filt & r_prev;

endmodule

// File: rtl/lsc_i2cs_16.sv
// I2C target with 7-bit address, 16-bit register offset and 8-bit data.
// Optional clock stretching for slow banks: define LSC_I2CS_STRETCH_EN.
module lsc_i2cs_16
  import lsc_i2cs_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEF_DEV_ADDR,
  parameter int unsigned FILT_LEN = 3,
  parameter logic [5:0]  SDA_HOLD = 6'd10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_out,
  output logic        sda_out,
  output logic [15:0] reg_addr,
  output logic        reg_wr,
  output logic [7:0]  reg_wdata,
  output logic        reg_rd,
  input  logic [7:0]  reg_rdata,
`ifdef LSC_I2CS_STRETCH_EN
  input  logic        reg_rvalid,
`endif
  output logic        busy
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  lsc_i2c_filt #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .resetn(resetn), .i_pad(scl_in),
    .o_lvl(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  lsc_i2c_filt #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .resetn(resetn), .i_pad(sda_in),
    .o_lvl(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shift, r_ofs_h, r_wdata;
  logic [15:0] r_addr;
  logic [5:0]  r_hcnt;
  logic        r_hpend, r_sda, r_busy, r_rw, r_rack_ok, r_wr, r_rd;
  logic        w_start, w_stop, w_match, w_rx, w_rd_go, w_drive;
  logic [7:0]  w_byte;

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;
  assign w_byte  = {r_shift[6:0], w_sda};
  assign w_match = (w_byte[7:1] == DEV_ADDR) && (w_byte[7:1] != 7'd0);
  assign w_rx    = (r_state == DEV) || (r_state == OFS_H) ||
                   (r_state == OFS_L) || (r_state == WDAT);
  assign w_rd_go = w_scl_fall & ~w_start & ~w_stop &
                   (w_state_nxt == RDAT) & (r_state != RDAT);

  // Receive states move to their ACK state on the falling edge after bit 8
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACK_DEV, ACK_H, ACK_L, ACK_W: w_drive = ACK;
      RDAT:                         w_drive = r_shift[7];
      default:                      w_drive = NACK;
    endcase
    if (w_start) begin
      w_state_nxt = DEV;
    end else if (w_stop) begin
      w_state_nxt = IDLE;
    end else if (w_scl_rise) begin
      if (r_state == DEV && r_bitcnt == 4'd7 && !w_match) w_state_nxt = IDLE;
      if (r_state == RACK && w_sda == NACK)               w_state_nxt = IDLE;
    end else if (w_scl_fall) begin
      case (r_state)
        DEV:     if (r_bitcnt == 4'd8) w_state_nxt = ACK_DEV;
        OFS_H:   if (r_bitcnt == 4'd8) w_state_nxt = ACK_H;
        OFS_L:   if (r_bitcnt == 4'd8) w_state_nxt = ACK_L;
        WDAT:    if (r_bitcnt == 4'd8) w_state_nxt = ACK_W;
        ACK_DEV: w_state_nxt = r_rw ? RDAT : OFS_H;
        ACK_H:   w_state_nxt = OFS_L;
        ACK_L:   w_state_nxt = WDAT;
        ACK_W:   w_state_nxt = WDAT;
        RDAT:    if (r_bitcnt == 4'd7) w_state_nxt = RACK;
        RACK:    if (r_rack_ok) w_state_nxt = RDAT;
        default: ;
      endcase
    end
  end

`ifdef LSC_I2CS_STRETCH_EN
  logic       r_scl, r_wait, r_son;
  logic [5:0] r_scnt;
`else
  logic       r_rd_d;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_ofs_h   <= '0;
      r_wdata   <= '0;
      r_addr    <= '0;
      r_hcnt    <= '0;
      r_hpend   <= 1'b0;
      r_sda     <= 1'b1;
      r_busy    <= 1'b0;
      r_rw      <= 1'b0;
      r_rack_ok <= 1'b0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
`ifdef LSC_I2CS_STRETCH_EN
      r_scl     <= 1'b1;
      r_wait    <= 1'b0;
      r_son     <= 1'b0;
      r_scnt    <= '0;
`else
      r_rd_d    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_wr    <= 1'b0;
      r_rd    <= w_rd_go;
      if (r_wr) r_addr <= r_addr + 16'd1;

      if (w_scl_fall) begin
        r_hpend <= 1'b1;
        r_hcnt  <= SDA_HOLD;
      end else if (r_hpend) begin
        if (r_hcnt <= 6'd1) begin
          r_sda   <= w_drive;
          r_hpend <= 1'b0;
        end else begin
          r_hcnt <= r_hcnt - 6'd1;
        end
      end

      if (w_start || w_stop) begin
        r_sda     <= 1'b1;
        r_hpend   <= 1'b0;
        r_bitcnt  <= '0;
        r_rack_ok <= 1'b0;
        if (w_stop) r_busy <= 1'b0;
      end else if (w_scl_rise) begin
        if (w_rx) begin
          r_shift  <= w_byte;
          r_bitcnt <= r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd7) begin
            case (r_state)
              DEV: begin
                r_busy <= w_match;
                r_rw   <= w_byte[0];
              end
              OFS_H:   r_ofs_h <= w_byte;
              OFS_L:   r_addr  <= {r_ofs_h, w_byte};
              WDAT: begin
                r_wdata <= w_byte;
                r_wr    <= 1'b1;
              end
              default: ;
            endcase
          end
        end else if (r_state == RACK) begin
          if (w_sda == ACK) begin
            r_addr    <= r_addr + 16'd1;
            r_rack_ok <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
      end else if (w_scl_fall) begin
        if (r_state == RDAT && r_bitcnt != 4'd7) begin
          r_shift  <= {r_shift[6:0], 1'b0};
          r_bitcnt <= r_bitcnt + 4'd1;
        end else if (!w_rx || r_bitcnt == 4'd8) begin
          r_bitcnt  <= '0;
          r_rack_ok <= 1'b0;
        end
      end

`ifdef LSC_I2CS_STRETCH_EN
      // Hold SCL low until read data arrives, then for SDA_HOLD more cycles
      if (w_rd_go) begin
        r_scl  <= 1'b0;
        r_wait <= 1'b1;
      end else if (r_wait && reg_rvalid) begin
        r_shift <= reg_rdata;
        r_wait  <= 1'b0;
        r_son   <= 1'b1;
        r_scnt  <= SDA_HOLD;
        r_hpend <= 1'b1;
        r_hcnt  <= SDA_HOLD;
      end else if (r_son) begin
        if (r_scnt <= 6'd1) begin
          r_scl <= 1'b1;
          r_son <= 1'b0;
        end else begin
          r_scnt <= r_scnt - 6'd1;
        end
      end
      if (w_start || w_stop) begin
        r_scl  <= 1'b1;
        r_wait <= 1'b0;
        r_son  <= 1'b0;
      end
`else
      r_rd_d <= r_rd;
      if (r_rd_d) r_shift <= reg_rdata;
`endif
    end
  end

`ifdef LSC_I2CS_STRETCH_EN
  assign scl_out = r_scl;
`else
  assign scl_out = 1'b1;
`endif
  assign sda_out   = r_sda;
  assign reg_addr  = r_addr;
  assign reg_wr    = r_wr;
  assign reg_wdata = r_wdata;
  assign reg_rd    = r_rd;
  assign busy      = r_busy;

endmodule

// File: tb/tb_lsc_i2cs_16.sv
// Directed bench for lsc_i2cs_16: bit-banged I2C master, register bank model,
// and strobe scoreboards for writes and reads.
module tb_lsc_i2cs_16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        scl_line, sda_line;
  logic        scl_out, sda_out;
  logic [15:0] reg_addr;
  logic        reg_wr, reg_rd, busy;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata = 8'h00;
`ifdef LSC_I2CS_STRETCH_EN
  logic        reg_rvalid = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [23:0] wr_q[$];
  logic [15:0] rd_q[$];

  assign scl_line = m_scl & scl_out;
  assign sda_line = m_sda & sda_out;

  always #10 clk = ~clk;

  lsc_i2cs_16 dut (
    .clk(clk), .resetn(resetn), .scl_in(scl_line), .sda_in(sda_line),
    .scl_out(scl_out), .sda_out(sda_out), .reg_addr(reg_addr),
    .reg_wr(reg_wr), .reg_wdata(reg_wdata), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata),
`ifdef LSC_I2CS_STRETCH_EN
    .reg_rvalid(reg_rvalid),
`endif
    .busy(busy)
  );

  // Bank returns the low byte of the offset, one clock after reg_rd
  always @(posedge clk) begin
    if (reg_rd) reg_rdata <= reg_addr[7:0];
`ifdef LSC_I2CS_STRETCH_EN
    reg_rvalid <= reg_rd;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reg_wr) begin
      chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        automatic logic [23:0] e = wr_q.pop_front();
        chk("wr_addr", 32'(reg_addr), 32'(e[23:8]));
        chk("wr_data", 32'(reg_wdata), 32'(e[7:0]));
      end
    end
    if (reg_rd) begin
      chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        automatic logic [15:0] e = rd_q.pop_front();
        chk("rd_addr", 32'(reg_addr), 32'(e));
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, input logic glitch, output logic s);
    m_sda = b;
    clks(30);
    m_scl = 1'b1;
    clks(15);
    if (glitch) begin
      m_sda = ~b;
      clks(1);
      m_sda = b;
    end else begin
      clks(1);
    end
    clks(14);
    s = sda_line;
    clks(30);
    m_scl = 1'b0;
    clks(30);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; clks(30);
    m_scl = 1'b1; clks(30);
    m_sda = 1'b0; clks(30);
    m_scl = 1'b0; clks(30);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; clks(30);
    m_scl = 1'b1; clks(30);
    m_sda = 1'b1; clks(60);
  endtask

  task automatic wbyte_g(input logic [7:0] b, input logic [7:0] gm, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], gm[i], s);
    bus_bit(1'b1, 1'b0, ack);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    wbyte_g(b, 8'h00, ack);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    bus_bit(mack, 1'b0, s);
  endtask

  initial begin
    #1_600_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       a;
    logic [7:0] d;
    logic       s;

    clks(5);
    chk("rst_sda_out",   32'(sda_out),   32'd1);
    chk("rst_scl_out",   32'(scl_out),   32'd1);
    chk("rst_reg_addr",  32'(reg_addr),  32'd0);
    chk("rst_reg_wr",    32'(reg_wr),    32'd0);
    chk("rst_reg_rd",    32'(reg_rd),    32'd0);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    resetn = 1'b1;
    clks(20);

    // Single write 0x3022 <= 0x01
    i2c_start();
    wbyte(8'h48, a); chk("t1_ack_dev", 32'(a), 32'd0);
    wbyte(8'h30, a); chk("t1_ack_h",   32'(a), 32'd0);
    wbyte(8'h22, a); chk("t1_ack_l",   32'(a), 32'd0);
    wr_q.push_back({16'h3022, 8'h01});
    wbyte(8'h01, a); chk("t1_ack_w",   32'(a), 32'd0);
    chk("t1_busy_hi", 32'(busy), 32'd1);
    i2c_stop();
    chk("t1_busy_lo", 32'(busy), 32'd0);
    chk("t1_addr_inc", 32'(reg_addr), 32'h3023);
    chk("t1_wr_done", 32'(wr_q.size()), 32'd0);

    // Burst write wrapping 0xFFFF -> 0x0000
    i2c_start();
    wbyte(8'h48, a); chk("t2_ack_dev", 32'(a), 32'd0);
    wbyte(8'hFF, a);
    wbyte(8'hFF, a);
    wr_q.push_back({16'hFFFF, 8'hAA});
    wr_q.push_back({16'h0000, 8'h55});
    wbyte(8'hAA, a); chk("t2_ack_w0", 32'(a), 32'd0);
    wbyte(8'h55, a); chk("t2_ack_w1", 32'(a), 32'd0);
    i2c_stop();
    chk("t2_addr_wrap", 32'(reg_addr), 32'h0001);
    chk("t2_wr_done", 32'(wr_q.size()), 32'd0);

    // Offset-only write, repeated START, 3-byte read
    i2c_start();
    wbyte(8'h48, a);
    wbyte(8'h00, a);
    wbyte(8'h00, a); chk("t3_ack_l", 32'(a), 32'd0);
    i2c_start();
    rd_q.push_back(16'h0000);
    rd_q.push_back(16'h0001);
    rd_q.push_back(16'h0002);
    wbyte(8'h49, a); chk("t3_ack_rd", 32'(a), 32'd0);
    rbyte(1'b0, d); chk("t3_rd0", 32'(d), 32'h00);
    rbyte(1'b0, d); chk("t3_rd1", 32'(d), 32'h01);
    rbyte(1'b1, d); chk("t3_rd2", 32'(d), 32'h02);
    clks(5);
    chk("t3_busy_nack", 32'(busy), 32'd0);
    i2c_stop();
    chk("t3_rd_done", 32'(rd_q.size()), 32'd0);
    chk("t3_addr", 32'(reg_addr), 32'h0002);

    // Wrong address and general call are not acknowledged
    i2c_start();
    wbyte(8'h4A, a); chk("t4_nack_0x25", 32'(a), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    i2c_stop();
    i2c_start();
    wbyte(8'h00, a); chk("t4_nack_gc", 32'(a), 32'd1);
    chk("t4_busy_gc", 32'(busy), 32'd0);
    i2c_stop();

    // 1-clk SDA glitches while SCL high (fake START on bit7, fake STOP on bit0)
    i2c_start();
    wbyte(8'h48, a);
    wbyte(8'h12, a);
    wbyte(8'h34, a);
    wr_q.push_back({16'h1234, 8'hF0});
    wbyte_g(8'hF0, 8'h81, a); chk("t5_ack_w", 32'(a), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    i2c_stop();
    chk("t5_wr_done", 32'(wr_q.size()), 32'd0);

    // STOP after 4 data bits: no write, offset stays set
    i2c_start();
    wbyte(8'h48, a);
    wbyte(8'h00, a);
    wbyte(8'h10, a);
    for (int i = 0; i < 4; i++) bus_bit(1'b1, 1'b0, s);
    i2c_stop();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_addr", 32'(reg_addr), 32'h0010);

    // Reset in the middle of a read while the target drives SDA low
    i2c_start();
    wbyte(8'h48, a);
    wbyte(8'h00, a);
    wbyte(8'h05, a);
    i2c_start();
    rd_q.push_back(16'h0005);
    wbyte(8'h49, a);
    bus_bit(1'b1, 1'b0, s); chk("t7_bit7", 32'(s), 32'd0);
    bus_bit(1'b1, 1'b0, s); chk("t7_bit6", 32'(s), 32'd0);
    chk("t7_driving", 32'(sda_out), 32'd0);
    resetn = 1'b0;
    clks(1);
    chk("t7_sda_out",   32'(sda_out),   32'd1);
    chk("t7_scl_out",   32'(scl_out),   32'd1);
    chk("t7_busy",      32'(busy),      32'd0);
    chk("t7_reg_addr",  32'(reg_addr),  32'd0);
    chk("t7_reg_wdata", 32'(reg_wdata), 32'd0);
    chk("t7_reg_rd",    32'(reg_rd),    32'd0);
    resetn = 1'b1;
    m_scl  = 1'b1;
    m_sda  = 1'b1;
    clks(50);
    chk("t7_rd_done", 32'(rd_q.size()), 32'd0);
    chk("t7_idle_busy", 32'(busy), 32'd0);
    chk("end_wr_q", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsc_i2cs_16.md
Name: lsc_i2cs_16

Overview:
- I2C target (responder) with a 7-bit device address, 16-bit register offset and 8-bit data. It is the far end of the 16-bit-offset master transaction the camera-init sequencer issues.
- Used as an on-FPGA sensor/register model for bring-up and loopback. It also lets an external host write and read a local register file.
- Oversamples SCL/SDA on the system clock and has no SCL-domain logic.
- Exposes a single-cycle register-access strobe interface to a synchronous RAM, ROM or register bank.

Parameters:
- DEV_ADDR, 7'h24, 7-bit address the target responds to.
- FILT_LEN, 3, number of consecutive identical samples needed to accept a new SCL/SDA level (glitch filter); legal range 1..15.
- SDA_HOLD, 6'd10, clk cycles after a filtered SCL falling edge before sda_out may change.

Ports:
- clk  in  1  system clock (48 MHz nominal).
- resetn  in  1  synchronous, active-low reset.
- scl_in  in  1  SCL pad input.
- sda_in  in  1  SDA pad input.
- scl_out  out  1  SCL open-drain drive; 0 = pull low, 1 = release.
- sda_out  out  1  SDA open-drain drive; 0 = pull low, 1 = release.
- reg_addr  out  16  register offset; auto-increments.
- reg_wr  out  1  one-cycle write strobe.
- reg_wdata  out  8  write data, valid while reg_wr is high.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, sampled exactly 1 clk after reg_rd.
- busy  out  1  high from an addressed START until STOP or NACK.

Behaviour:
- Reset (resetn = 0 at a clk edge) sets: state IDLE; sda_out = 1; scl_out = 1; reg_addr = 0; reg_wr = 0; reg_rd = 0; reg_wdata = 0; busy = 0. Filters and synchronizers preset to 1.
- Input conditioning:
  - 2-flop synchronizer, then the FILT_LEN stability filter.
  - Edge and START/STOP detection use filtered signals only.
- START / STOP detection:
  - START = filtered SDA falls while filtered SCL is high.
  - STOP = filtered SDA rises while filtered SCL is high.
  - Both are recognised in any state and take priority over bit processing in the same cycle.
- Bit timing:
  - Input bits are sampled on the filtered SCL rising edge, MSB first.
  - sda_out is updated SDA_HOLD cycles after the filtered SCL falling edge.
- FSM states: IDLE, DEV, ACK_DEV, OFS_H, ACK_H, OFS_L, ACK_L, WDAT, ACK_W, RDAT, RACK.
  - START → DEV, from any state; this covers repeated start. The bit counter clears and sda_out = 1.
  - DEV, after 8 bits:
    - address matches DEV_ADDR → ACK_DEV; busy = 1.
    - address mismatch → IDLE, with no ACK driven.
  - ACK_DEV: drive 0 for one SCL period. Then:
    - R/W = 0 → OFS_H.
    - R/W = 1 → RDAT; reg_rd pulses on the ACK falling edge; reg_rdata is latched into the shift register 1 clk later.
  - OFS_H → ACK_H: 8 bits latched into the offset high byte, ACK.
  - ACK_H → OFS_L.
  - OFS_L → ACK_L: low byte latched; reg_addr is updated at the end of the 8th bit; ACK.
  - ACK_L → WDAT.
  - WDAT → ACK_W: reg_wdata is loaded and reg_wr pulses 1 clk on the 8th SCL rising edge.
  - ACK_W → WDAT. reg_addr += 1 after the reg_wr cycle.
  - RDAT: shift out 8 bits, MSB first. On the 8th SCL falling edge release SDA → RACK.
  - RACK, sampled on the SCL rising edge:
    - master ACK (0) → reg_addr += 1; reg_rd pulses on the next SCL falling edge → RDAT.
    - master NACK (1) → IDLE; busy = 0.
  - STOP → IDLE from any state: sda_out = 1, busy = 0. No reg_wr is issued for a partial byte.
- Arithmetic and boundaries:
  - reg_addr wraps 16'hFFFF → 16'h0000 without error.
  - A partial byte interrupted by START or STOP is discarded.
  - Writes with 0 data bytes (offset only) leave reg_addr set. A following repeated-start read begins at that offset.
- Reset mid-transfer returns to IDLE on the next clk edge. The bus is released within 1 cycle.
- General call (address 0) is not acknowledged.

Optional Feature:
- Macro: LSC_I2CS_STRETCH_EN.
- Defined: in RDAT, after the reg_rd strobe, scl_out = 0 is held from the ACK falling edge until reg_rdata has been latched plus SDA_HOLD cycles. This supports slow banks; reg_rd latency then becomes "sampled when reg_rvalid = 1", and the input port reg_rvalid is added.
- Undefined: scl_out is constant 1, there is no reg_rvalid port, and latency is fixed at 1 clk.

Decomposition:
- Package lsc_i2cs_pkg:
  - state encoding constants (4-bit).
  - default DEV_ADDR.
  - ACK = 1'b0, NACK = 1'b1.
- Sub-module lsc_i2c_filt: a one-bit synchronizer plus stability filter plus rise/fall pulses, instantiated for SCL and SDA.

Test Plan:
- Write 0x24, offset 0x3022, data 0x01 → ACK on all 4 bytes; reg_wr once with reg_addr = 0x3022 and reg_wdata = 0x01; busy falls after STOP.
- Burst write at offset 0xFFFF with data 0xAA, 0x55 → reg_wr at 0xFFFF then 0x0000 (wrap).
- Write offset 0x0000, repeated START, read 3 bytes (ACK, ACK, NACK) with bank value = addr[7:0] → SDA bytes 0x00, 0x01, 0x02; reg_rd pulses 3 times; IDLE after NACK.
- Address 0x25 write → no ACK (SDA = 1 at the 9th clock); no strobes; busy stays 0.
- A 1-clk SDA glitch while SCL is high, with FILT_LEN = 3 → no START/STOP detected; the transfer completes normally.
- STOP after 4 data bits, and resetn = 0 mid-read → no reg_wr; all outputs return to reset values; sda_out = 1.
